// File: rtl/pea_pkg.sv
// Shared types, widths and the requantizer for the PE-array psum collector.
// PSUM_COLLECT_RELU_EN: when defined, negative requant results clamp to zero.
package pea_pkg;

    localparam int ACC_WIDTH = 32;
    localparam int OUT_WIDTH = 8;
    localparam int PV_LAT    = 3;
    localparam int SAT_MAX   = 2**(OUT_WIDTH-1) - 1;
    localparam int SAT_MIN   = -(2**(OUT_WIDTH-1));

    typedef enum logic {D_IDLE, D_SEND} drain_state_e;

    function automatic logic [OUT_WIDTH-1:0] sat_requant(
        input logic signed [ACC_WIDTH-1:0] acc,
        input logic        [4:0]           shift
    );
        logic signed [ACC_WIDTH-1:0] v;
        v = acc >>> shift;
`ifdef PSUM_COLLECT_RELU_EN
        if (v < 0) v = '0;
`endif
        if (v > ACC_WIDTH'(SAT_MAX))      return OUT_WIDTH'(SAT_MAX);
        else if (v < ACC_WIDTH'(SAT_MIN)) return OUT_WIDTH'(SAT_MIN);
        else                              return v[OUT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/psum_bank.sv
// One accumulator bank: TILE_LEN entries of COL lanes, write-or-accumulate
// on the fill side and a registered read port on the drain side.
module psum_bank
    import pea_pkg::*;
#(
    parameter int COL        = 8,
    parameter int DEPTH      = 16,
    parameter int PSUM_WIDTH = 24,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       i_wr_en,
    input  logic                       i_wr_first,
    input  logic [AW-1:0]              i_wr_addr,
    input  logic [COL-1:0]             i_wr_mask,
    input  logic [COL*PSUM_WIDTH-1:0]  i_wr_psum,
    input  logic                       i_rd_en,
    input  logic [AW-1:0]              i_rd_addr,
    output logic [COL*ACC_WIDTH-1:0]   o_rd_data,
    output logic [COL-1:0]             o_rd_mask
);

    logic [COL*ACC_WIDTH-1:0] r_mem      [DEPTH];
    logic [COL-1:0]           r_mask_mem [DEPTH];

    function automatic logic [ACC_WIDTH-1:0] sext(input logic [PSUM_WIDTH-1:0] p);
        return {{(ACC_WIDTH-PSUM_WIDTH){p[PSUM_WIDTH-1]}}, p};
    endfunction

    // NOTE: storage arrays carry no reset; every entry is written on the first pass before it is read.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            if (i_wr_first) r_mask_mem[i_wr_addr] <= i_wr_mask;
            for (int i = 0; i < COL; i++) begin
                if (i_wr_first)
                    r_mem[i_wr_addr][i*ACC_WIDTH +: ACC_WIDTH] <=
                        sext(i_wr_psum[i*PSUM_WIDTH +: PSUM_WIDTH]);
                else if (i_wr_mask[i])
                    r_mem[i_wr_addr][i*ACC_WIDTH +: ACC_WIDTH] <=
                        r_mem[i_wr_addr][i*ACC_WIDTH +: ACC_WIDTH] +
                        sext(i_wr_psum[i*PSUM_WIDTH +: PSUM_WIDTH]);
            end
        end
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_rd_data <= '0;
            o_rd_mask <= '0;
        end else if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
            o_rd_mask <= r_mask_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/psum_collect_33.sv
// Psum collector: accumulates ic passes into a double bank, drains finished oc
// tiles through requant to a valid/ready port. PSUM_COLLECT_RELU_EN selects ReLU.
module psum_collect_33
    import pea_pkg::*;
#(
    parameter int COL        = 8,
    parameter int TILE_LEN   = 16,
    parameter int PSUM_WIDTH = 24
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start_conv,
    input  logic [4:0]                shift,
    input  logic [COL-1:0]            pvalid,
    input  logic [COL*PSUM_WIDTH-1:0] psum,
    input  logic                      ic_done,
    input  logic                      oc_done,
    input  logic                      conv_done,
    output logic                      ofm_valid,
    input  logic                      ofm_ready,
    output logic [COL*OUT_WIDTH-1:0]  ofm_data,
    output logic [COL-1:0]            ofm_mask,
    output logic                      ofm_last,
    output logic                      ofm_conv_last,
    output logic                      busy,
    output logic                      err_overrun
);

    localparam int PTR_W = $clog2(TILE_LEN);
    localparam int CNT_W = PTR_W + 1;

    logic [PV_LAT-1:0] r_icd_sr, r_ocd_sr, r_cvd_sr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic              r_first_pass, r_fill_bank;
    logic [CNT_W-1:0]  r_n_ent;

    drain_state_e      r_state;
    logic              r_drain_bank, r_rd_vld, r_rd_last, r_conv_tag;
    logic [CNT_W-1:0]  r_rd_ptr, r_n_drain;
    logic              r_ofm_valid, r_ofm_last, r_ofm_conv_last, r_err;
    logic [COL*OUT_WIDTH-1:0] r_ofm_data;
    logic [COL-1:0]           r_ofm_mask;

    logic              w_icd, w_ocd, w_cvd, w_beat, w_sat_err, w_overrun;
    logic              w_issue, w_load, w_accept_last;
    logic [CNT_W-1:0]  w_cnt;
    logic [COL*ACC_WIDTH-1:0] w_rd_data_0, w_rd_data_1, w_sel_data;
    logic [COL-1:0]           w_rd_mask_0, w_rd_mask_1;
    logic [COL*OUT_WIDTH-1:0] w_q;

    assign w_icd  = r_icd_sr[PV_LAT-1];
    assign w_ocd  = r_ocd_sr[PV_LAT-1];
    assign w_cvd  = r_cvd_sr[PV_LAT-1];
    assign w_beat = |pvalid;
    // A single-pass tile hands off before n_ent is latched, so count live.
    assign w_cnt  = r_first_pass ? CNT_W'(r_wr_ptr) + CNT_W'(1) : r_n_ent;

    assign w_sat_err     = w_beat && !w_icd && (r_wr_ptr == PTR_W'(TILE_LEN-1));
    assign w_accept_last = r_ofm_valid && ofm_ready && r_ofm_last;
    assign w_overrun     = w_ocd && (r_state == D_SEND) && !w_accept_last;
    assign w_load        = r_rd_vld && (!r_ofm_valid || ofm_ready);
    assign w_issue       = (r_state == D_SEND) && (r_rd_ptr != r_n_drain) && (!r_rd_vld || w_load);

    psum_bank #(.COL(COL), .DEPTH(TILE_LEN), .PSUM_WIDTH(PSUM_WIDTH)) u_bank0 (
        .clk(clk), .rstn(rstn),
        .i_wr_en(w_beat && !r_fill_bank), .i_wr_first(r_first_pass), .i_wr_addr(r_wr_ptr),
        .i_wr_mask(pvalid), .i_wr_psum(psum),
        .i_rd_en(w_issue && !r_drain_bank), .i_rd_addr(r_rd_ptr[PTR_W-1:0]),
        .o_rd_data(w_rd_data_0), .o_rd_mask(w_rd_mask_0)
    );

    psum_bank #(.COL(COL), .DEPTH(TILE_LEN), .PSUM_WIDTH(PSUM_WIDTH)) u_bank1 (
        .clk(clk), .rstn(rstn),
        .i_wr_en(w_beat && r_fill_bank), .i_wr_first(r_first_pass), .i_wr_addr(r_wr_ptr),
        .i_wr_mask(pvalid), .i_wr_psum(psum),
        .i_rd_en(w_issue && r_drain_bank), .i_rd_addr(r_rd_ptr[PTR_W-1:0]),
        .o_rd_data(w_rd_data_1), .o_rd_mask(w_rd_mask_1)
    );

    assign w_sel_data = r_drain_bank ? w_rd_data_1 : w_rd_data_0;

    // NOTE: default assignment first so no path through always_comb infers a latch.
    always_comb begin
        w_q = '0;
        for (int i = 0; i < COL; i++)
            w_q[i*OUT_WIDTH +: OUT_WIDTH] = sat_requant(w_sel_data[i*ACC_WIDTH +: ACC_WIDTH], shift);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_icd_sr <= '0; r_ocd_sr <= '0; r_cvd_sr <= '0;
            r_wr_ptr <= '0; r_first_pass <= 1'b1; r_fill_bank <= 1'b0; r_n_ent <= '0;
        end else if (start_conv) begin
            r_icd_sr <= '0; r_ocd_sr <= '0; r_cvd_sr <= '0;
            r_wr_ptr <= '0; r_first_pass <= 1'b1; r_fill_bank <= 1'b0; r_n_ent <= '0;
        end else begin
            r_icd_sr <= {r_icd_sr[PV_LAT-2:0], ic_done};
            r_ocd_sr <= {r_ocd_sr[PV_LAT-2:0], oc_done};
            r_cvd_sr <= {r_cvd_sr[PV_LAT-2:0], conv_done};
            if (w_icd || w_ocd)
                r_wr_ptr <= '0;
            else if (w_beat && !w_sat_err)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_ocd) begin
                r_first_pass <= 1'b1;
                r_fill_bank  <= ~r_fill_bank;
            end else if (w_icd) begin
                r_first_pass <= 1'b0;
                if (r_first_pass) r_n_ent <= w_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)           r_err <= 1'b0;
        else if (start_conv) r_err <= 1'b0;
        else if (w_sat_err || w_overrun) r_err <= 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn || start_conv) begin
            r_state <= D_IDLE; r_drain_bank <= 1'b0; r_rd_ptr <= '0; r_n_drain <= '0;
            r_rd_vld <= 1'b0; r_rd_last <= 1'b0; r_conv_tag <= 1'b0;
            r_ofm_valid <= 1'b0; r_ofm_data <= '0; r_ofm_mask <= '0;
            r_ofm_last <= 1'b0; r_ofm_conv_last <= 1'b0;
        end else if (w_ocd) begin
            // New tile wins: any drain in flight is abandoned.
            r_state <= D_SEND; r_drain_bank <= r_fill_bank; r_n_drain <= w_cnt;
            r_rd_ptr <= '0; r_rd_vld <= 1'b0; r_conv_tag <= w_cvd;
            r_ofm_valid <= 1'b0; r_ofm_last <= 1'b0; r_ofm_conv_last <= 1'b0;
        end else begin
            if (w_issue) begin
                r_rd_ptr  <= r_rd_ptr + CNT_W'(1);
                r_rd_last <= (r_rd_ptr == r_n_drain - CNT_W'(1));
            end
            if (w_issue)     r_rd_vld <= 1'b1;
            else if (w_load) r_rd_vld <= 1'b0;
            if (w_load) begin
                r_ofm_valid     <= 1'b1;
                r_ofm_data      <= w_q;
                r_ofm_mask      <= r_drain_bank ? w_rd_mask_1 : w_rd_mask_0;
                r_ofm_last      <= r_rd_last;
                r_ofm_conv_last <= r_rd_last && r_conv_tag;
            end else if (ofm_ready) begin
                r_ofm_valid <= 1'b0; r_ofm_last <= 1'b0; r_ofm_conv_last <= 1'b0;
            end
            if (w_accept_last) r_state <= D_IDLE;
        end
    end

    assign ofm_valid     = r_ofm_valid;
    assign ofm_data      = r_ofm_data;
    assign ofm_mask      = r_ofm_mask;
    assign ofm_last      = r_ofm_last;
    assign ofm_conv_last = r_ofm_conv_last;
    assign err_overrun   = r_err;
    assign busy          = (r_state != D_IDLE) || !r_first_pass || (r_wr_ptr != '0);

endmodule

// File: tb/tb_psum_collect_33.sv
// Directed self-checking bench for psum_collect_33.
`timescale 1ns/1ps
module tb_psum_collect_33;
    import pea_pkg::*;

    localparam int COL = 8, TILE_LEN = 16, PSUM_WIDTH = 24;

    logic clk = 1'b0, rstn = 1'b0, start_conv = 1'b0;
    logic [4:0] shift = '0;
    logic [COL-1:0] pvalid = '0;
    logic [COL*PSUM_WIDTH-1:0] psum = '0;
    logic ic_done = 1'b0, oc_done = 1'b0, conv_done = 1'b0, ofm_ready = 1'b0;
    logic ofm_valid, ofm_last, ofm_conv_last, busy, err_overrun;
    logic [COL*OUT_WIDTH-1:0] ofm_data;
    logic [COL-1:0] ofm_mask;

    int n_checks = 0, n_fail = 0;

    typedef struct packed {
        logic [COL*OUT_WIDTH-1:0] data;
        logic [COL-1:0]           mask;
        logic                     last;
        logic                     conv_last;
    } beat_t;
    beat_t q[$];

    psum_collect_33 #(.COL(COL), .TILE_LEN(TILE_LEN), .PSUM_WIDTH(PSUM_WIDTH)) dut (
        .clk(clk), .rstn(rstn), .start_conv(start_conv), .shift(shift),
        .pvalid(pvalid), .psum(psum), .ic_done(ic_done), .oc_done(oc_done),
        .conv_done(conv_done), .ofm_valid(ofm_valid), .ofm_ready(ofm_ready),
        .ofm_data(ofm_data), .ofm_mask(ofm_mask), .ofm_last(ofm_last),
        .ofm_conv_last(ofm_conv_last), .busy(busy), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    // Collect accepted beats; inputs only change just after posedge.
    always @(negedge clk)
        if (rstn && ofm_valid && ofm_ready)
            q.push_back({ofm_data, ofm_mask, ofm_last, ofm_conv_last});

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_conv = 1'b1;
        tick();
        start_conv = 1'b0;
    endtask

    function automatic logic [COL*OUT_WIDTH-1:0] lanes(input int v, input logic [COL-1:0] m);
        logic [COL*OUT_WIDTH-1:0] r;
        r = '0;
        for (int l = 0; l < COL; l++)
            if (m[l]) r[l*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(v);
        return r;
    endfunction

    // Controller pulses go out PV_LAT cycles ahead of the last beat.
    task automatic send_pass(input int nb, input logic [COL-1:0] pv, input int base,
                             input int step, input logic oc, input logic cv);
        for (int c = 0; c < nb; c++) begin
            pvalid = pv;
            for (int l = 0; l < COL; l++)
                psum[l*PSUM_WIDTH +: PSUM_WIDTH] = pv[l] ? PSUM_WIDTH'(base + c*step) : '0;
            ic_done   = (c == nb - 1 - PV_LAT);
            oc_done   = ic_done & oc;
            conv_done = ic_done & cv;
            tick();
        end
        pvalid = '0; psum = '0; ic_done = 1'b0; oc_done = 1'b0; conv_done = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (q.size() < n && k < budget) begin
            tick();
            k++;
        end
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        n_checks++; if (ofm_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", ofm_valid); end
        n_checks++; if (ofm_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h, expected 0", ofm_data); end
        n_checks++; if (ofm_mask !== '0) begin n_fail++; $display("FAIL reset_mask: got %h, expected 0", ofm_mask); end
        n_checks++; if ({ofm_last, ofm_conv_last} !== 2'b00) begin n_fail++; $display("FAIL reset_last: got %b%b, expected 00", ofm_last, ofm_conv_last); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        n_checks++; if (err_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, expected 0", err_overrun); end
    endtask

    task automatic test_single_pass();
        beat_t exp, got;
        q.delete(); shift = 5'd8; ofm_ready = 1'b1;
        pulse_start();
        send_pass(16, 8'hFF, 0, 256, 1'b1, 1'b0);
        n_checks++; if (err_overrun !== 1'b0) begin n_fail++; $display("FAIL single_full_tile_err: got %b, expected 0", err_overrun); end
        wait_beats(16, 100);
        n_checks++; if (q.size() != 16) begin n_fail++; $display("FAIL single_count: got %0d, expected 16", q.size()); end
        for (int c = 0; c < 16; c++) begin
            exp = {lanes(c, 8'hFF), 8'hFF, (c == 15), 1'b0};
            got = (c < q.size()) ? q[c] : '0;
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL single beat %0d: got %h, expected %h", c, got, exp); end
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b, expected 0", busy); end
    endtask

    task automatic test_saturate();
        beat_t exp, got;
        logic [OUT_WIDTH-1:0] neg_exp;
`ifdef PSUM_COLLECT_RELU_EN
        neg_exp = 8'h00;
`else
        neg_exp = 8'h80;
`endif
        q.delete(); shift = 5'd0; ofm_ready = 1'b1;
        pulse_start();
        for (int p = 0; p < 4; p++) send_pass(4, 8'hFF, 100, 0, (p == 3), 1'b0);
        wait_beats(4, 100);
        n_checks++; if (q.size() != 4) begin n_fail++; $display("FAIL sat_pos_count: got %0d, expected 4", q.size()); end
        for (int c = 0; c < 4; c++) begin
            exp = {lanes(8'h7F, 8'hFF), 8'hFF, (c == 3), 1'b0};
            got = (c < q.size()) ? q[c] : '0;
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL sat_pos beat %0d: got %h, expected %h", c, got, exp); end
        end
        q.delete();
        pulse_start();
        for (int p = 0; p < 4; p++) send_pass(4, 8'hFF, -100, 0, (p == 3), (p == 3));
        wait_beats(4, 100);
        n_checks++; if (q.size() != 4) begin n_fail++; $display("FAIL sat_neg_count: got %0d, expected 4", q.size()); end
        for (int c = 0; c < 4; c++) begin
            exp = {lanes(int'(neg_exp), 8'hFF), 8'hFF, (c == 3), (c == 3)};
            got = (c < q.size()) ? q[c] : '0;
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL sat_neg beat %0d: got %h, expected %h", c, got, exp); end
        end
    endtask

    task automatic test_partial_tile();
        beat_t exp, got;
        q.delete(); shift = 5'd0; ofm_ready = 1'b1;
        pulse_start();
        send_pass(5, 8'h1F, 10, 1, 1'b0, 1'b0);
        send_pass(5, 8'h1F, 10, 1, 1'b1, 1'b1);
        wait_beats(5, 100);
        n_checks++; if (q.size() != 5) begin n_fail++; $display("FAIL partial_count: got %0d, expected 5", q.size()); end
        for (int c = 0; c < 5; c++) begin
            exp = {lanes(20 + 2*c, 8'h1F), 8'h1F, (c == 4), (c == 4)};
            got = (c < q.size()) ? q[c] : '0;
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL partial beat %0d: got %h, expected %h", c, got, exp); end
        end
    endtask

    task automatic test_back_to_back();
        beat_t exp, got;
        logic stalled;
        logic [COL*OUT_WIDTH-1:0] held;
        q.delete(); shift = 5'd0; ofm_ready = 1'b0;
        stalled = 1'b0; held = '0;
        pulse_start();
        fork
            begin
                send_pass(4, 8'hFF, 1, 1, 1'b1, 1'b0);
                send_pass(16, 8'hFF, 50, 1, 1'b1, 1'b0);
            end
            begin
                for (int k = 0; k < 80; k++) begin
                    @(posedge clk); #1;
                    ofm_ready = k[0];
                    @(negedge clk);
                    if (stalled && ofm_valid) begin
                        n_checks++;
                        if (ofm_data !== held) begin n_fail++; $display("FAIL stall_stable cycle %0d: got %h, expected %h", k, ofm_data, held); end
                    end
                    stalled = ofm_valid && !ofm_ready;
                    held = ofm_data;
                end
                @(posedge clk); #1;
                ofm_ready = 1'b1;
            end
        join
        wait_beats(20, 100);
        n_checks++; if (q.size() != 20) begin n_fail++; $display("FAIL b2b_count: got %0d, expected 20", q.size()); end
        for (int c = 0; c < 20; c++) begin
            if (c < 4) exp = {lanes(1 + c, 8'hFF), 8'hFF, (c == 3), 1'b0};
            else       exp = {lanes(50 + c - 4, 8'hFF), 8'hFF, (c == 19), 1'b0};
            got = (c < q.size()) ? q[c] : '0;
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL b2b beat %0d: got %h, expected %h", c, got, exp); end
        end
        n_checks++; if (err_overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %b, expected 0", err_overrun); end
    endtask

    task automatic test_ptr_saturate();
        ofm_ready = 1'b1;
        pulse_start();
        pvalid = 8'hFF;
        psum = '0;
        repeat (15) tick();
        n_checks++; if (err_overrun !== 1'b0) begin n_fail++; $display("FAIL ptr_15_err: got %b, expected 0", err_overrun); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ptr_busy: got %b, expected 1", busy); end
        tick();
        pvalid = '0;
        n_checks++; if (err_overrun !== 1'b1) begin n_fail++; $display("FAIL ptr_16_err: got %b, expected 1", err_overrun); end
        pulse_start();
        n_checks++; if ({err_overrun, busy} !== 2'b00) begin n_fail++; $display("FAIL ptr_clear: got %b%b, expected 00", err_overrun, busy); end
    endtask

    task automatic test_overrun();
        beat_t exp, got;
        int k;
        q.delete(); shift = 5'd0; ofm_ready = 1'b0;
        pulse_start();
        send_pass(4, 8'hFF, 1, 1, 1'b1, 1'b0);
        send_pass(4, 8'hFF, 9, 1, 1'b1, 1'b0);
        n_checks++; if (err_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b, expected 1", err_overrun); end
        repeat (5) tick();
        n_checks++; if (err_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b, expected 1", err_overrun); end
        ofm_ready = 1'b1;
        wait_beats(4, 100);
        n_checks++; if (q.size() != 4) begin n_fail++; $display("FAIL ovr_count: got %0d, expected 4", q.size()); end
        for (int c = 0; c < 4; c++) begin
            exp = {lanes(9 + c, 8'hFF), 8'hFF, (c == 3), 1'b0};
            got = (c < q.size()) ? q[c] : '0;
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL ovr beat %0d: got %h, expected %h", c, got, exp); end
        end
        n_checks++; if (err_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_after_drain: got %b, expected 1", err_overrun); end
        pulse_start();
        n_checks++; if (err_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_start_clear: got %b, expected 0", err_overrun); end
        ofm_ready = 1'b0;
        send_pass(4, 8'hFF, 3, 1, 1'b1, 1'b0);
        k = 0;
        while (!ofm_valid && k < 20) begin tick(); k++; end
        n_checks++; if (ofm_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %b, expected 1", ofm_valid); end
        #2;
        rstn = 1'b0;
        #1;
        n_checks++; if (ofm_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b, expected 0", ofm_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy: got %b, expected 0", busy); end
        tick();
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_saturate();
        test_partial_tile();
        test_back_to_back();
        test_ptr_saturate();
        test_overrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
